// File: rtl/btn_start_stop_ctrl.sv
// Two-button start/stop front-end: synchronize, debounce and edge-detect each button,
// then gate the press events through a run/idle FSM. Define BTN_ACTIVE_LOW_EN for pull-up buttons.
module btn_start_stop_ctrl #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int CNT_W           = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_start,
    input  logic i_btn_stop,
    output logic o_start,
    output logic o_stop,
    output logic o_running
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Bit 0 carries the start button, bit 1 the stop button.
    logic [1:0]       raw_s;
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       stable_r;
    logic [1:0]       stable_d_r;
    logic [1:0]       press_s;
    logic [CNT_W-1:0] cnt_r [2];

    state_t state_r;
    state_t state_nxt_s;
    logic   start_nxt_s;
    logic   stop_nxt_s;
    logic   start_r;
    logic   stop_r;
    logic   running_r;

`ifdef BTN_ACTIVE_LOW_EN
    assign raw_s = ~{i_btn_stop, i_btn_start};
`else
    assign raw_s = {i_btn_stop, i_btn_start};
`endif

    // Synchronizer and debounce counters; any disagreement streak shorter than the window restarts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 2'b00;
            sync2_r    <= 2'b00;
            stable_r   <= 2'b00;
            stable_d_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r    <= raw_s;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_MAX) begin
                    stable_r[i] <= sync2_r[i];
                    cnt_r[i]    <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    assign press_s = stable_r & ~stable_d_r;

    // Next-state logic: stop always has priority over start.
    always_comb begin
        state_nxt_s = state_r;
        start_nxt_s = 1'b0;
        stop_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (press_s[0] && !press_s[1]) begin
                    state_nxt_s = ST_RUNNING;
                    start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                if (press_s[1]) begin
                    state_nxt_s = ST_IDLE;
                    stop_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RUNNING;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            start_r   <= 1'b0;
            stop_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            start_r   <= start_nxt_s;
            stop_r    <= stop_nxt_s;
            running_r <= (state_nxt_s == ST_RUNNING);
        end
    end

    assign o_start   = start_r;
    assign o_stop    = stop_r;
    assign o_running = running_r;

endmodule

// File: tb/tb_btn_start_stop_ctrl.sv
// Directed bench for btn_start_stop_ctrl with DEBOUNCE_CYCLES=4; works with or without BTN_ACTIVE_LOW_EN.
module tb_btn_start_stop_ctrl;

    localparam int D = 4;

`ifdef BTN_ACTIVE_LOW_EN
    localparam logic PRS = 1'b0;
`else
    localparam logic PRS = 1'b1;
`endif
    localparam logic REL = ~PRS;

    logic clk;
    logic rst;
    logic btn_start;
    logic btn_stop;
    logic o_start;
    logic o_stop;
    logic o_running;

    int check_cnt;
    int error_cnt;
    int start_seen;
    int stop_seen;

    btn_start_stop_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_btn_start(btn_start),
        .i_btn_stop (btn_stop),
        .o_start    (o_start),
        .o_stop     (o_stop),
        .o_running  (o_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge; inputs set afterwards are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input int n);
        start_seen = 0;
        stop_seen  = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            start_seen += int'(o_start);
            stop_seen  += int'(o_stop);
            check_eq("excl", 32'(o_start & o_stop), 32'd0);
        end
    endtask

    // pre quiet edges, then the pulse edge, then one edge where the pulse must be gone.
    task automatic pulse_after(input int pre, input logic exp_start, input logic exp_stop,
                               input logic run_before, input logic run_after);
        for (int i = 0; i < pre; i++) begin
            tick();
            check_eq("pre_start", 32'(o_start), 32'd0);
            check_eq("pre_stop", 32'(o_stop), 32'd0);
            check_eq("pre_run", 32'(o_running), 32'(run_before));
        end
        tick();
        check_eq("pulse_start", 32'(o_start), 32'(exp_start));
        check_eq("pulse_stop", 32'(o_stop), 32'(exp_stop));
        check_eq("pulse_run", 32'(o_running), 32'(run_after));
        tick();
        check_eq("post_start", 32'(o_start), 32'd0);
        check_eq("post_stop", 32'(o_stop), 32'd0);
        check_eq("post_run", 32'(o_running), 32'(run_after));
    endtask

    initial begin
        check_cnt = 0;
        error_cnt = 0;
        rst       = 1'b1;
        btn_start = REL;
        btn_stop  = REL;
        tick();
        tick();
        check_eq("rst_start", 32'(o_start), 32'd0);
        check_eq("rst_stop", 32'(o_stop), 32'd0);
        check_eq("rst_run", 32'(o_running), 32'd0);
        rst = 1'b0;

        // Idle inputs must produce nothing.
        run_count(10);
        check_eq("idle_start", 32'(start_seen), 32'd0);
        check_eq("idle_run", 32'(o_running), 32'd0);

        // Clean start press: sampled at edge 0, pulse at edge D+2.
        btn_start = PRS;
        pulse_after(D + 2, 1'b1, 1'b0, 1'b0, 1'b1);
        btn_start = REL;
        run_count(10);
        check_eq("rel_start_n", 32'(start_seen), 32'd0);
        check_eq("rel_stop_n", 32'(stop_seen), 32'd0);
        check_eq("rel_run", 32'(o_running), 32'd1);

        // Start while running is ignored.
        btn_start = PRS;
        run_count(12);
        check_eq("rerun_start_n", 32'(start_seen), 32'd0);
        check_eq("rerun_stop_n", 32'(stop_seen), 32'd0);
        check_eq("rerun_run", 32'(o_running), 32'd1);
        btn_start = REL;
        run_count(10);

        // Stop press while running.
        btn_stop = PRS;
        pulse_after(D + 2, 1'b0, 1'b1, 1'b1, 1'b0);
        btn_stop = REL;
        run_count(10);
        check_eq("stop_rel_start_n", 32'(start_seen), 32'd0);
        check_eq("stop_rel_stop_n", 32'(stop_seen), 32'd0);
        check_eq("stop_rel_run", 32'(o_running), 32'd0);

        // Bounce 1,0,1,0 then hold: final level sampled at edge 4, pulse at edge 10.
        for (int k = 0; k < 4; k++) begin
            btn_start = (k % 2 == 0) ? PRS : REL;
            tick();
            check_eq("bounce_start", 32'(o_start), 32'd0);
        end
        btn_start = PRS;
        pulse_after(D + 2, 1'b1, 1'b0, 1'b0, 1'b1);
        run_count(10);
        check_eq("hold_start_n", 32'(start_seen), 32'd0);
        btn_start = REL;
        run_count(10);

        // Reset while running with a start press mid-debounce (cnt=2), button held through release.
        btn_start = PRS;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        check_eq("pre_rst_run", 32'(o_running), 32'd1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_start", 32'(o_start), 32'd0);
        check_eq("mid_rst_stop", 32'(o_stop), 32'd0);
        check_eq("mid_rst_run", 32'(o_running), 32'd0);
        tick();
        rst = 1'b0;
        pulse_after(D + 2, 1'b1, 1'b0, 1'b0, 1'b1);
        run_count(10);
        check_eq("post_rst_hold_n", 32'(start_seen), 32'd0);
        btn_start = REL;
        run_count(10);

        // Both pressed while running: stop wins.
        btn_start = PRS;
        btn_stop  = PRS;
        pulse_after(D + 2, 1'b0, 1'b1, 1'b1, 1'b0);
        run_count(10);
        check_eq("both_run_start_n", 32'(start_seen), 32'd0);
        check_eq("both_run_stop_n", 32'(stop_seen), 32'd0);
        btn_start = REL;
        btn_stop  = REL;
        run_count(10);

        // Both pressed while idle: nothing happens.
        btn_start = PRS;
        btn_stop  = PRS;
        run_count(16);
        check_eq("both_idle_start_n", 32'(start_seen), 32'd0);
        check_eq("both_idle_stop_n", 32'(stop_seen), 32'd0);
        check_eq("both_idle_run", 32'(o_running), 32'd0);
        btn_start = REL;
        btn_stop  = REL;
        run_count(10);

        // Start still works afterwards.
        btn_start = PRS;
        pulse_after(D + 2, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
